// File: rtl/led_receiver.sv
`default_nettype none
// ============================================================================
// led_receiver : WS2812-style NRZ decoder producing 24-bit GRB pixels and
//                a full-frame word, with glitch/stuck/bit-count error flags.
// Revision     : 1.0
// ============================================================================
module led_receiver #(
  parameter int BIT_THRESH   = 15,
  parameter int MIN_HIGH     = 4,
  parameter int MAX_HIGH     = 40,
  parameter int LATCH_CYCLES = 1200,
  parameter int NUM_BITS     = 144
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  input  logic                clr_err,
  output logic [23:0]         pixel,
  output logic                pixel_valid,
  output logic [2:0]          pixel_idx,
  output logic [NUM_BITS-1:0] rgb_out,
  output logic                frame_valid,
  output logic [2:0]          err
);

  localparam logic [7:0]  BIT_THRESH_C = 8'(BIT_THRESH);
  localparam logic [7:0]  MIN_HIGH_C   = 8'(MIN_HIGH);
  localparam logic [7:0]  MAX_HIGH_C   = 8'(MAX_HIGH);
  localparam logic [15:0] LATCH_C      = 16'(LATCH_CYCLES);
  localparam logic [7:0]  NUM_BITS_C   = 8'(NUM_BITS);
  localparam logic [7:0]  PIX_BITS_C   = 8'd24;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                din_s_q, din_s_d;
  logic                din_prev_q, din_prev_d;
  logic [7:0]          hi_cnt_q, hi_cnt_d;
  logic [15:0]         lo_cnt_q, lo_cnt_d;
  logic [7:0]          bit_cnt_q, bit_cnt_d;
  logic                ovf_q, ovf_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic [23:0]         pixel_q, pixel_d;
  logic [2:0]          pixel_idx_q, pixel_idx_d;
  logic                pixel_valid_q, pixel_valid_d;
  logic [NUM_BITS-1:0] rgb_out_q, rgb_out_d;
  logic                frame_valid_q, frame_valid_d;
  logic [2:0]          err_q, err_d;

  logic rise;
  logic fall;
  logic set_glitch;
  logic set_stuck;
  logic set_badcnt;

  always_comb begin
    sync1_d    = din;
    din_s_d    = sync1_q;
    din_prev_d = din_s_q;
  end

  assign rise = din_s_q & ~din_prev_q;
  assign fall = ~din_s_q & din_prev_q;

  always_comb begin
    state_d       = state_q;
    hi_cnt_d      = hi_cnt_q;
    lo_cnt_d      = lo_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    ovf_d         = ovf_q;
    shreg_d       = shreg_q;
    pixel_d       = pixel_q;
    pixel_idx_d   = pixel_idx_q;
    pixel_valid_d = 1'b0;
    rgb_out_d     = rgb_out_q;
    frame_valid_d = 1'b0;
    set_glitch    = 1'b0;
    set_stuck     = 1'b0;
    set_badcnt    = 1'b0;

    case (state_q)
      // Wait out any pulse already in flight when reset released.
      ST_ARM: begin
        hi_cnt_d = 8'd0;
        lo_cnt_d = 16'd0;
        if (!din_s_q) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (rise) begin
          state_d  = ST_HIGH;
          hi_cnt_d = 8'd1;
        end
      end

      ST_HIGH: begin
        if (hi_cnt_q >= MAX_HIGH_C) begin
          set_stuck = 1'b1;
          bit_cnt_d = 8'd0;
          ovf_d     = 1'b0;
          shreg_d   = '0;
          hi_cnt_d  = 8'd0;
          state_d   = ST_ARM;
        end else if (fall) begin
          lo_cnt_d = 16'd1;
          state_d  = ST_LOW;
          if (hi_cnt_q < MIN_HIGH_C) begin
            set_glitch = 1'b1;
          end else if (bit_cnt_q < NUM_BITS_C) begin
            shreg_d   = {shreg_q[NUM_BITS-2:0], (hi_cnt_q >= BIT_THRESH_C)};
            bit_cnt_d = bit_cnt_q + 8'd1;
            if ((bit_cnt_d % PIX_BITS_C) == 8'd0) begin
              pixel_d       = shreg_d[23:0];
              pixel_idx_d   = 3'(bit_cnt_d / PIX_BITS_C - 8'd1);
              pixel_valid_d = 1'b1;
            end
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          hi_cnt_d = hi_cnt_q + 8'd1;
        end
      end

      ST_LOW: begin
        if (lo_cnt_q >= LATCH_C) begin
          if ((bit_cnt_q == NUM_BITS_C) && !ovf_q) begin
            rgb_out_d     = shreg_q;
            frame_valid_d = 1'b1;
          end else if ((bit_cnt_q != 8'd0) || ovf_q) begin
            set_badcnt = 1'b1;
          end
          bit_cnt_d = 8'd0;
          ovf_d     = 1'b0;
          shreg_d   = '0;
          lo_cnt_d  = 16'd0;
          // A rise landing exactly on the latch cycle starts the next frame.
          if (rise) begin
            state_d  = ST_HIGH;
            hi_cnt_d = 8'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (rise) begin
          state_d  = ST_HIGH;
          hi_cnt_d = 8'd1;
        end else if (lo_cnt_q != 16'hFFFF) begin
          lo_cnt_d = lo_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_ARM;
      end
    endcase

    err_d = (clr_err ? 3'b000 : err_q) | {set_badcnt, set_stuck, set_glitch};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ARM;
      sync1_q       <= 1'b0;
      din_s_q       <= 1'b0;
      din_prev_q    <= 1'b0;
      hi_cnt_q      <= 8'd0;
      lo_cnt_q      <= 16'd0;
      bit_cnt_q     <= 8'd0;
      ovf_q         <= 1'b0;
      shreg_q       <= '0;
      pixel_q       <= 24'd0;
      pixel_idx_q   <= 3'd0;
      pixel_valid_q <= 1'b0;
      rgb_out_q     <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 3'b000;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      din_s_q       <= din_s_d;
      din_prev_q    <= din_prev_d;
      hi_cnt_q      <= hi_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      ovf_q         <= ovf_d;
      shreg_q       <= shreg_d;
      pixel_q       <= pixel_d;
      pixel_idx_q   <= pixel_idx_d;
      pixel_valid_q <= pixel_valid_d;
      rgb_out_q     <= rgb_out_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_idx   = pixel_idx_q;
  assign rgb_out     = rgb_out_q;
  assign frame_valid = frame_valid_q;
  assign err         = err_q;

endmodule
`default_nettype wire
